wb_rr_arbiter: RTL and testbench

- Round-robin Wishbone B3 arbiter that shares one slave port among NUM_MASTERS bus-functional or RTL masters.
- Grant is held for a master's whole cycle (cyc_i high), including classic, incrementing and constant-address bursts, so bursts are never split.
- A per-transfer watchdog terminates hung transfers with an error so that simulations and systems do not deadlock.
- Sits between the master-side BFMs/CPU ports and a single slave or interconnect segment.

---
 rtl/wb_rr_arbiter_if.sv | 57 +++++
 rtl/wb_rr_arbiter.sv | 117 +++++++++++
 tb/tb_wb_rr_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for the round-robin Wishbone arbiter. It carries the packed master-side
// vectors, the single slave-side port, and the status outputs (grant_o, timeout_o).
interface wb_rr_arbiter_if #(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned aw          = 32,
   parameter int unsigned dw          = 32
);
   // master-facing side; master k owns slice [k*w +: w]
   logic [NUM_MASTERS*aw-1:0] m_adr_i;
   logic [NUM_MASTERS*dw-1:0] m_dat_i;
   logic [NUM_MASTERS*4-1:0]  m_sel_i;
   logic [NUM_MASTERS-1:0]    m_we_i;
   logic [NUM_MASTERS-1:0]    m_cyc_i;
   logic [NUM_MASTERS-1:0]    m_stb_i;
   logic [NUM_MASTERS*3-1:0]  m_cti_i;
   logic [NUM_MASTERS*2-1:0]  m_bte_i;
   logic [dw-1:0]             m_dat_o;
   logic [NUM_MASTERS-1:0]    m_ack_o;
   logic [NUM_MASTERS-1:0]    m_err_o;
   logic [NUM_MASTERS-1:0]    m_rty_o;

   // shared slave-facing side
   logic [aw-1:0]             s_adr_o;
   logic [dw-1:0]             s_dat_o;
   logic [3:0]                s_sel_o;
   logic                      s_we_o;
   logic                      s_cyc_o;
   logic                      s_stb_o;
   logic [2:0]                s_cti_o;
   logic [1:0]                s_bte_o;
   logic [dw-1:0]             s_dat_i;
   logic                      s_ack_i;
   logic                      s_err_i;
   logic                      s_rty_i;

   // status
   logic [NUM_MASTERS-1:0]    grant_o;
   logic                      timeout_o;

   // Environment side: the requesting masters together with the shared slave
   modport master (
      output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
      output s_dat_i, s_ack_i, s_err_i, s_rty_i,
      input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
      input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
      input  grant_o, timeout_o
   );

   // Arbiter side
   modport slave (
      input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
      input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
      output m_dat_o, m_ack_o, m_err_o, m_rty_o,
      output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
      output grant_o, timeout_o
   );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: one owner per whole cyc tenure, with a
// per-beat watchdog that ends hung transfers by signalling an error.
module wb_rr_arbiter #(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned aw          = 32,
   parameter int unsigned dw          = 32,
   parameter int unsigned TIMEOUT     = 256
) (
   input logic           wb_clk_i,
   input logic           wb_rst_i,
   wb_rr_arbiter_if.slave bus
);
   localparam int unsigned  IW       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int unsigned  CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic         WD_EN    = (TIMEOUT != 0);
   localparam logic [CW-1:0] CNT_MAX = CW'((TIMEOUT != 0) ? TIMEOUT - 1 : 0);
   localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);

   typedef enum logic {ST_IDLE, ST_OWNED} state_e;

   state_e                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IW-1:0]          last_q, last_d;   // last winner; equals the owner while OWNED
   logic [CW-1:0]          cnt_q, cnt_d;

   logic                   pick_vld;
   logic [IW-1:0]          pick;
   logic [IW-1:0]          idx;
   logic                   owned;
   logic                   own_cyc;
   logic                   stb_raw;
   logic                   resp;
   logic                   fire;

   // Round-robin pick and tenure FSM next-state
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      pick_vld = 1'b0;
      pick     = last_q;
      idx      = '0;
      for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
         idx = IW'((32'(last_q) + i) % NUM_MASTERS);
         if (!pick_vld && bus.m_cyc_i[idx]) begin
            pick_vld = 1'b1;
            pick     = idx;
         end
      end
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               state_d = ST_OWNED;
               grant_d = NUM_MASTERS'(1) << pick;
               last_d  = pick;
            end
         end
         ST_OWNED: begin
            if (!bus.m_cyc_i[last_q]) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Watchdog: counts unanswered strobe cycles; fires on the last allowed one
   always_comb begin
      owned   = (state_q == ST_OWNED);
      own_cyc = owned & bus.m_cyc_i[last_q];
      stb_raw = own_cyc & bus.m_stb_i[last_q];
      resp    = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
      fire    = WD_EN & stb_raw & ~resp & (cnt_q == CNT_MAX);
      cnt_d   = '0;
      if (WD_EN && stb_raw && !resp && !fire) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // State, grant, pointer and watchdog registers
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= LAST_RST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Slave-side mux from the registered owner; zero when idle. A firing
   // watchdog withdraws the strobe so the beat is terminated only once.
   assign bus.s_adr_o   = owned ? bus.m_adr_i[32'(last_q) * aw +: aw] : '0;
   assign bus.s_dat_o   = owned ? bus.m_dat_i[32'(last_q) * dw +: dw] : '0;
   assign bus.s_sel_o   = owned ? bus.m_sel_i[32'(last_q) * 4 +: 4]   : '0;
   assign bus.s_cti_o   = owned ? bus.m_cti_i[32'(last_q) * 3 +: 3]   : '0;
   assign bus.s_bte_o   = owned ? bus.m_bte_i[32'(last_q) * 2 +: 2]   : '0;
   assign bus.s_we_o    = owned & bus.m_we_i[last_q];
   assign bus.s_cyc_o   = own_cyc;
   assign bus.s_stb_o   = stb_raw & ~fire;

   // Responses routed to the owner only
   assign bus.m_dat_o   = bus.s_dat_i;
   assign bus.m_ack_o   = grant_q & {NUM_MASTERS{bus.s_ack_i}};
   assign bus.m_err_o   = grant_q & {NUM_MASTERS{bus.s_err_i | fire}};
   assign bus.m_rty_o   = grant_q & {NUM_MASTERS{bus.s_rty_i}};
   assign bus.grant_o   = grant_q;
   assign bus.timeout_o = fire;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: two masters, 32-bit bus, 16-cycle watchdog.
module tb_wb_rr_arbiter;
   localparam int unsigned NM = 2;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 16;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wb_rr_arbiter_if #(.NUM_MASTERS(NM), .aw(AW), .dw(DW)) bus ();

   wb_rr_arbiter #(.NUM_MASTERS(NM), .aw(AW), .dw(DW), .TIMEOUT(TO)) dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst_n),
      .bus     (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0; bus.m_we_i = '0;
      bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_cti_i = '0; bus.m_bte_i = '0;
      bus.s_dat_i = '0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
   endtask

   task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
      bus.m_cyc_i[k] = cyc;
      bus.m_stb_i[k] = stb;
      bus.m_we_i[k]  = we;
      bus.m_adr_i[k*AW +: AW] = adr;
      bus.m_dat_i[k*DW +: DW] = dat;
      bus.m_sel_i[k*4 +: 4]   = 4'hF;
      bus.m_cti_i[k*3 +: 3]   = cti;
      bus.m_bte_i[k*2 +: 2]   = 2'b00;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      bus.m_cyc_i[0] = 1'b1;
      #2;
      checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", bus.grant_o); end
      checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b want 0", bus.s_cyc_o); end
      checks++; if (bus.timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", bus.timeout_o); end
      checks++; if ({bus.m_ack_o, bus.m_err_o, bus.m_rty_o} !== 6'b0) begin errors++; $display("FAIL reset_resp: got %b want 000000", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o}); end
      tick();
      checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL reset_held_grant: got %b want 00", bus.grant_o); end
      clear_inputs();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      do_reset();
      set_m(1, 1'b1, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 3'b000);
      #1;
      checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL single_no_early_cyc: got %b want 0", bus.s_cyc_o); end
      tick();
      checks++; if (bus.grant_o !== 2'b10) begin errors++; $display("FAIL single_grant: got %b want 10", bus.grant_o); end
      checks++; if (bus.s_cyc_o !== 1'b1 || bus.s_stb_o !== 1'b1) begin errors++; $display("FAIL single_cyc_stb: got %b%b want 11", bus.s_cyc_o, bus.s_stb_o); end
      checks++; if (bus.s_adr_o !== 32'h100) begin errors++; $display("FAIL single_adr: got %h want 00000100", bus.s_adr_o); end
      checks++; if (bus.s_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_dat: got %h want deadbeef", bus.s_dat_o); end
      checks++; if (bus.s_sel_o !== 4'hF || bus.s_we_o !== 1'b1) begin errors++; $display("FAIL single_sel_we: got %h/%b want f/1", bus.s_sel_o, bus.s_we_o); end
      bus.s_ack_i = 1'b1;
      #1;
      checks++; if (bus.m_ack_o !== 2'b10) begin errors++; $display("FAIL single_ack: got %b want 10", bus.m_ack_o); end
      tick();
      set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      bus.s_ack_i = 1'b0;
      #1;
      checks++; if (bus.m_ack_o !== 2'b00 || bus.grant_o !== 2'b10) begin errors++; $display("FAIL single_hold: got ack %b grant %b want 00/10", bus.m_ack_o, bus.grant_o); end
      tick();
      checks++; if (bus.grant_o !== 2'b00 || bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL single_release: got %b/%b want 00/0", bus.grant_o, bus.s_cyc_o); end
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_g;
      logic [31:0] exp_a;
      logic [31:0] exp_d;
      do_reset();
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h1000, 32'h0, 3'b000);
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h1100, 32'h0, 3'b000);
      for (int t = 0; t < 4; t++) begin
         exp_g = 2'(1 << (t % 2));
         exp_a = 32'h1000 + 32'((t % 2) * 32'h100);
         exp_d = 32'hA5000000 | 32'(t);
         tick();
         checks++; if (bus.grant_o !== exp_g) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", t, bus.grant_o, exp_g); end
         checks++; if (bus.s_adr_o !== exp_a) begin errors++; $display("FAIL rr_adr[%0d]: got %h want %h", t, bus.s_adr_o, exp_a); end
         bus.s_ack_i = 1'b1;
         bus.s_dat_i = exp_d;
         #1;
         checks++; if (bus.m_ack_o !== exp_g) begin errors++; $display("FAIL rr_ack[%0d]: got %b want %b", t, bus.m_ack_o, exp_g); end
         checks++; if (bus.m_dat_o !== exp_d) begin errors++; $display("FAIL rr_rdata[%0d]: got %h want %h", t, bus.m_dat_o, exp_d); end
         tick();
         bus.s_ack_i = 1'b0;
         set_m(t % 2, 1'b0, 1'b0, 1'b0, exp_a, 32'h0, 3'b000);
         tick();
         checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL rr_idle_gap[%0d]: got %b want 00", t, bus.grant_o); end
         if (t < 3) set_m(t % 2, 1'b1, 1'b1, 1'b0, exp_a, 32'h0, 3'b000);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_burst();
      logic [2:0] cti;
      do_reset();
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 3'b010);
      tick();
      checks++; if (bus.grant_o !== 2'b01) begin errors++; $display("FAIL burst_grant: got %b want 01", bus.grant_o); end
      for (int b = 0; b < 8; b++) begin
         cti = (b == 7) ? 3'b111 : 3'b010;
         set_m(0, 1'b1, 1'b1, 1'b0, 32'h200 + 32'(4 * b), 32'h0, cti);
         if (b == 2) set_m(1, 1'b1, 1'b1, 1'b0, 32'h900, 32'h0, 3'b000);
         bus.s_ack_i = 1'b1;
         #1;
         checks++; if (bus.m_ack_o !== 2'b01) begin errors++; $display("FAIL burst_ack[%0d]: got %b want 01", b, bus.m_ack_o); end
         checks++; if (bus.s_adr_o !== 32'h200 + 32'(4 * b) || bus.s_cti_o !== cti) begin errors++; $display("FAIL burst_adr_cti[%0d]: got %h/%b want %h/%b", b, bus.s_adr_o, bus.s_cti_o, 32'h200 + 32'(4 * b), cti); end
         tick();
      end
      set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      bus.s_ack_i = 1'b0;
      #1;
      checks++; if (bus.grant_o !== 2'b01) begin errors++; $display("FAIL burst_hold_after_last: got %b want 01", bus.grant_o); end
      tick();
      checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL burst_release: got %b want 00", bus.grant_o); end
      tick();
      checks++; if (bus.grant_o !== 2'b10 || bus.s_adr_o !== 32'h900) begin errors++; $display("FAIL burst_next_owner: got %b/%h want 10/00000900", bus.grant_o, bus.s_adr_o); end
      clear_inputs();
      tick();
   endtask

   task automatic test_watchdog();
      do_reset();
      set_m(0, 1'b1, 1'b1, 1'b1, 32'h300, 32'h55, 3'b000);
      tick();
      for (int k = 0; k < 15; k++) begin
         checks++; if (bus.timeout_o !== 1'b0 || bus.s_stb_o !== 1'b1) begin errors++; $display("FAIL wd_early[%0d]: got to=%b stb=%b want 0/1", k, bus.timeout_o, bus.s_stb_o); end
         tick();
      end
      checks++; if (bus.timeout_o !== 1'b1 || bus.m_err_o !== 2'b01) begin errors++; $display("FAIL wd_fire: got to=%b err=%b want 1/01", bus.timeout_o, bus.m_err_o); end
      checks++; if (bus.s_stb_o !== 1'b0 || bus.m_ack_o !== 2'b00) begin errors++; $display("FAIL wd_fire_stb: got stb=%b ack=%b want 0/00", bus.s_stb_o, bus.m_ack_o); end
      tick();
      checks++; if (bus.timeout_o !== 1'b0 || bus.m_err_o !== 2'b00) begin errors++; $display("FAIL wd_single_pulse: got to=%b err=%b want 0/00", bus.timeout_o, bus.m_err_o); end
      bus.m_stb_i[0] = 1'b0;
      tick();
      bus.m_stb_i[0] = 1'b1;
      for (int k = 0; k < 15; k++) begin
         #1;
         checks++; if (bus.timeout_o !== 1'b0) begin errors++; $display("FAIL wd_restart_early[%0d]: got %b want 0", k, bus.timeout_o); end
         tick();
      end
      checks++; if (bus.timeout_o !== 1'b1 || bus.m_err_o !== 2'b01) begin errors++; $display("FAIL wd_refire: got to=%b err=%b want 1/01", bus.timeout_o, bus.m_err_o); end
      tick();
      bus.m_stb_i[0] = 1'b0;
      tick();
      bus.m_stb_i[0] = 1'b1;
      for (int k = 0; k < 15; k++) tick();
      bus.s_ack_i = 1'b1;
      #1;
      checks++; if (bus.timeout_o !== 1'b0 || bus.m_err_o !== 2'b00) begin errors++; $display("FAIL wd_ack_wins: got to=%b err=%b want 0/00", bus.timeout_o, bus.m_err_o); end
      checks++; if (bus.m_ack_o !== 2'b01 || bus.s_stb_o !== 1'b1) begin errors++; $display("FAIL wd_ack_wins_ack: got ack=%b stb=%b want 01/1", bus.m_ack_o, bus.s_stb_o); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 3'b010);
      tick();
      for (int b = 0; b < 3; b++) begin
         set_m(0, 1'b1, 1'b1, 1'b0, 32'h400 + 32'(4 * b), 32'h0, 3'b010);
         bus.s_ack_i = 1'b1;
         tick();
      end
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h40C, 32'h0, 3'b010);
      set_m(1, 1'b1, 1'b1, 1'b0, 32'hA00, 32'h0, 3'b000);
      #1;
      checks++; if (bus.s_cyc_o !== 1'b1 || bus.grant_o !== 2'b01) begin errors++; $display("FAIL rstmid_pre: got cyc=%b grant=%b want 1/01", bus.s_cyc_o, bus.grant_o); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.grant_o !== 2'b00 || bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin errors++; $display("FAIL rstmid_async: got grant=%b cyc=%b stb=%b want 00/0/0", bus.grant_o, bus.s_cyc_o, bus.s_stb_o); end
      checks++; if (bus.s_adr_o !== 32'h0 || bus.m_ack_o !== 2'b00) begin errors++; $display("FAIL rstmid_outs: got adr=%h ack=%b want 0/00", bus.s_adr_o, bus.m_ack_o); end
      tick();
      rst_n = 1'b1;
      bus.s_ack_i = 1'b0;
      tick();
      checks++; if (bus.grant_o !== 2'b01) begin errors++; $display("FAIL rstmid_first_win: got %b want 01", bus.grant_o); end
      clear_inputs();
      tick();
   endtask

   task automatic test_err_passthrough();
      do_reset();
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 3'b010);
      set_m(1, 1'b1, 1'b1, 1'b0, 32'hB00, 32'h0, 3'b000);
      tick();
      bus.s_ack_i = 1'b1;
      #1;
      checks++; if (bus.m_ack_o !== 2'b01) begin errors++; $display("FAIL errp_beat0_ack: got %b want 01", bus.m_ack_o); end
      tick();
      bus.s_ack_i = 1'b0;
      bus.s_rty_i = 1'b1;
      #1;
      checks++; if (bus.m_rty_o !== 2'b01) begin errors++; $display("FAIL errp_rty: got %b want 01", bus.m_rty_o); end
      tick();
      bus.s_rty_i = 1'b0;
      bus.s_err_i = 1'b1;
      #1;
      checks++; if (bus.m_err_o !== 2'b01 || bus.m_ack_o !== 2'b00) begin errors++; $display("FAIL errp_err: got err=%b ack=%b want 01/00", bus.m_err_o, bus.m_ack_o); end
      tick();
      bus.s_err_i = 1'b0;
      bus.m_stb_i[0] = 1'b0;
      #1;
      checks++; if (bus.grant_o !== 2'b01) begin errors++; $display("FAIL errp_hold: got %b want 01", bus.grant_o); end
      tick();
      checks++; if (bus.grant_o !== 2'b01) begin errors++; $display("FAIL errp_hold2: got %b want 01", bus.grant_o); end
      bus.m_cyc_i[0] = 1'b0;
      tick();
      checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL errp_release: got %b want 00", bus.grant_o); end
      tick();
      checks++; if (bus.grant_o !== 2'b10) begin errors++; $display("FAIL errp_next: got %b want 10", bus.grant_o); end
      clear_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_burst();
      test_watchdog();
      test_reset_mid_burst();
      test_err_passthrough();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got still running want finished");
      $fatal(1);
   end
endmodule
